// File: rtl/mage_ff_one_pipe.sv
// Pipelined find-first-one / zero-count unit with valid/ready handshake and flush.
// A binary priority tree over LEN leaves is split by register stages between tree levels.
module mage_ff_one_pipe #(
    parameter  int LEN         = 32,
    parameter  int PIPE_STAGES = 2,
    parameter  int TAG_W       = 4,
    localparam int NUM_LEVELS  = $clog2(LEN),
    localparam int IDX_W       = NUM_LEVELS,
    localparam int RES_W       = $clog2(LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [LEN-1:0]   in_data_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RES_W-1:0] result_o,
    output logic             no_ones_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int PS    = PIPE_STAGES;
    localparam int NL    = NUM_LEVELS;
    localparam int NLEAF = 1 << NL;

    // Returns the stage (1..PS-1) whose register sits after tree level lvl, or 0 if none.
    function automatic int bnd_stage(input int lvl);
        int r;
        r = 0;
        for (int s = 1; s < PS; s++) begin
            if ((s * NL + PS - 1) / PS == lvl) r = s;
        end
        return r;
    endfunction

    logic          live_q, live_d;
    logic [PS:0]   rdy;
    logic [PS-1:0] load;

    assign rdy[PS]    = out_ready_i;
    assign in_ready_o = live_q & rdy[0] & ~flush_i;

    always_comb live_d = 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) live_q <= 1'b0;
        else          live_q <= live_d;
    end

    // Per-stage handshake state; mode is only carried as far as the final result logic needs it.
    for (genvar gi = 0; gi < PS; gi++) begin : g_stg
        logic             valid_q, valid_d, up_valid;
        logic [TAG_W-1:0] tag_q, tag_d, up_tag;

        if (gi == 0) begin : g_src0
            assign up_valid = in_valid_i & in_ready_o;
            assign up_tag   = in_tag_i;
        end else begin : g_srcn
            assign up_valid = g_stg[gi-1].valid_q;
            assign up_tag   = g_stg[gi-1].tag_q;
        end

        assign rdy[gi]  = ~valid_q | rdy[gi+1];
        assign load[gi] = rdy[gi] & up_valid & ~flush_i;

        always_comb begin
            valid_d = valid_q;
            tag_d   = tag_q;
            if (flush_i)      valid_d = 1'b0;
            else if (rdy[gi]) valid_d = up_valid;
            if (load[gi])     tag_d   = up_tag;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                tag_q   <= tag_d;
            end
        end

        if (gi < PS - 1) begin : g_mode
            logic [1:0] mode_q, mode_d, up_mode;
            if (gi == 0) begin : g_m0
                assign up_mode = mode_i;
            end else begin : g_mn
                assign up_mode = g_stg[gi-1].g_mode.mode_q;
            end
            always_comb mode_d = load[gi] ? up_mode : mode_q;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) mode_q <= 2'b00;
                else          mode_q <= mode_d;
            end
        end
    end

    // Tree levels: level 0 are the leaves, level NL is the root.
    for (genvar gi = 0; gi <= NL; gi++) begin : g_lvl
        localparam int N  = NLEAF >> gi;
        localparam int BS = bnd_stage(gi);
        logic [N-1:0]       any_c, any_o;
        logic [N*IDX_W-1:0] idx_c, idx_o;

        if (gi == 0) begin : g_leaf
            logic rev;
            assign rev   = (mode_i == 2'b01) | (mode_i == 2'b10);
            assign idx_c = '0;
            for (genvar gj = 0; gj < N; gj++) begin : g_bit
                if (gj < LEN) begin : g_real
                    assign any_c[gj] = rev ? in_data_i[LEN-1-gj] : in_data_i[gj];
                end else begin : g_pad
                    assign any_c[gj] = 1'b0;
                end
            end
        end else begin : g_node
            for (genvar gj = 0; gj < N; gj++) begin : g_n
                assign any_c[gj] = g_lvl[gi-1].any_o[2*gj] | g_lvl[gi-1].any_o[2*gj+1];
                // Lower leaf wins ties; the right child's index gains this level's bit.
                assign idx_c[gj*IDX_W +: IDX_W] = g_lvl[gi-1].any_o[2*gj]
                    ? g_lvl[gi-1].idx_o[2*gj*IDX_W +: IDX_W]
                    : (g_lvl[gi-1].idx_o[(2*gj+1)*IDX_W +: IDX_W] | IDX_W'(1 << (gi - 1)));
            end
        end

        if (BS != 0) begin : g_reg
            logic [N-1:0]       any_q, any_d;
            logic [N*IDX_W-1:0] idx_q, idx_d;
            always_comb begin
                any_d = load[BS-1] ? any_c : any_q;
                idx_d = load[BS-1] ? idx_c : idx_q;
            end
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    any_q <= '0;
                    idx_q <= '0;
                end else begin
                    any_q <= any_d;
                    idx_q <= idx_d;
                end
            end
            assign any_o = any_q;
            assign idx_o = idx_q;
        end else begin : g_comb
            assign any_o = any_c;
            assign idx_o = idx_c;
        end
    end

    logic             root_any;
    logic [IDX_W-1:0] root_idx;
    logic [1:0]       fin_mode;
    logic [RES_W-1:0] res_q, res_d;
    logic             nz_q, nz_d;

    assign root_any = g_lvl[NL].any_o[0];
    assign root_idx = g_lvl[NL].idx_o[IDX_W-1:0];

    if (PS == 1) begin : g_fm_in
        assign fin_mode = mode_i;
    end else begin : g_fm_reg
        assign fin_mode = g_stg[PS-2].g_mode.mode_q;
    end

    always_comb begin
        res_d = res_q;
        nz_d  = nz_q;
        if (load[PS-1]) begin
            nz_d = ~root_any;
            if (!root_any)              res_d = fin_mode[1] ? RES_W'(LEN) : '0;
            else if (fin_mode == 2'b01) res_d = RES_W'(LEN - 1) - RES_W'(root_idx);
            else                        res_d = RES_W'(root_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_q <= '0;
            nz_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            nz_q  <= nz_d;
        end
    end

    assign out_valid_o = g_stg[PS-1].valid_q;
    assign tag_o       = g_stg[PS-1].tag_q;
    assign result_o    = res_q;
    assign no_ones_o   = nz_q;

endmodule

// File: tb/tb_mage_ff_one_pipe.sv
// Bench for mage_ff_one_pipe: directed handshake/flush/reset cases plus a randomized
// stream scored against a scan-based reference, on a 32/2 and a 24/3 instance.
module tb_mage_ff_one_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_nz;
    logic [31:0] a_data;
    logic [1:0]  a_mode;
    logic [3:0]  a_tag_i, a_tag_o;
    logic [5:0]  a_res;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_nz;
    logic [23:0] b_data;
    logic [1:0]  b_mode;
    logic [3:0]  b_tag_i, b_tag_o;
    logic [4:0]  b_res;

    mage_ff_one_pipe #(.LEN(32), .PIPE_STAGES(2), .TAG_W(4)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_data),
        .mode_i(a_mode), .in_tag_i(a_tag_i), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .result_o(a_res), .no_ones_o(a_nz), .tag_o(a_tag_o)
    );

    mage_ff_one_pipe #(.LEN(24), .PIPE_STAGES(3), .TAG_W(4)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_data),
        .mode_i(b_mode), .in_tag_i(b_tag_i), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .result_o(b_res), .no_ones_o(b_nz), .tag_o(b_tag_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: scan the vector for lowest/highest set bit and derive each mode's answer.
    function automatic logic [6:0] ref_calc(input logic [31:0] d, input logic [1:0] m, input int len);
        int lo, hi;
        lo = -1;
        hi = -1;
        for (int i = 0; i < len; i++) begin
            if (d[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) return {1'b1, (m[1] ? 6'(len) : 6'd0)};
        case (m)
            2'd0:    return {1'b0, 6'(lo)};
            2'd1:    return {1'b0, 6'(hi)};
            2'd2:    return {1'b0, 6'(len - 1 - hi)};
            default: return {1'b0, 6'(lo)};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic v, input logic [31:0] d, input logic [1:0] m,
                         input logic [3:0] t, input logic ordy, input logic fl);
        a_in_valid = v; a_data = d; a_mode = m; a_tag_i = t; a_out_ready = ordy; a_flush = fl;
    endtask

    task automatic a_send(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t,
                          input logic [5:0] er, input logic enz);
        a_set(1'b1, d, m, t, 1'b1, 1'b0);
        #1 chk("a_accept_rdy", a_in_ready, 1);
        tick;
        a_in_valid = 1'b0;
        #1 chk("a_lat1_vld", a_out_valid, 0);
        tick;
        #1;
        chk("a_lat2_vld", a_out_valid, 1);
        chk("a_result", a_res, er);
        chk("a_no_ones", a_nz, enz);
        chk("a_tag", a_tag_o, t);
        $display("txn A data=%08h mode=%0d tag=%0d -> result=%0d no_ones=%0d", d, m, t, a_res, a_nz);
        tick;
    endtask

    task automatic b_send(input logic [23:0] d, input logic [1:0] m, input logic [3:0] t,
                          input logic [4:0] er, input logic enz);
        b_in_valid = 1'b1; b_data = d; b_mode = m; b_tag_i = t;
        #1 chk("b_accept_rdy", b_in_ready, 1);
        tick;
        b_in_valid = 1'b0;
        #1 chk("b_lat1_vld", b_out_valid, 0);
        tick;
        #1 chk("b_lat2_vld", b_out_valid, 0);
        tick;
        #1;
        chk("b_lat3_vld", b_out_valid, 1);
        chk("b_result", b_res, er);
        chk("b_no_ones", b_nz, enz);
        chk("b_tag", b_tag_o, t);
        $display("txn B data=%06h mode=%0d tag=%0d -> result=%0d no_ones=%0d", d, m, t, b_res, b_nz);
        tick;
    endtask

    logic [10:0] q[$];
    logic [6:0]  e;
    bit          prev_stall, post_flush;
    int          rsel;

    initial begin
        a_set(1'b0, 32'h0, 2'd0, 4'd0, 1'b1, 1'b0);
        b_flush = 1'b0; b_in_valid = 1'b0; b_data = '0; b_mode = 2'd0; b_tag_i = '0; b_out_ready = 1'b1;

        #12;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_result", a_res, 0);
        chk("rst_no_ones", a_nz, 0);
        chk("rst_tag", a_tag_o, 0);
        chk("rst_in_ready", a_in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        chk("rel_in_ready", a_in_ready, 1);
        chk("rel_b_in_ready", b_in_ready, 1);

        a_send(32'h0000_0100, 2'd0, 4'd3, 6'd8, 1'b0);
        a_send(32'h8000_0001, 2'd0, 4'd1, 6'd0, 1'b0);
        a_send(32'h8000_0001, 2'd1, 4'd2, 6'd31, 1'b0);
        a_send(32'h8000_0001, 2'd2, 4'd3, 6'd0, 1'b0);
        a_send(32'h8000_0001, 2'd3, 4'd4, 6'd0, 1'b0);
        a_send(32'h0000_0000, 2'd2, 4'd5, 6'd32, 1'b1);
        a_send(32'h0000_0000, 2'd1, 4'd6, 6'd0, 1'b1);

        // Back-to-back tags 1..3 against a stalled consumer.
        a_set(1'b1, 32'h2, 2'd0, 4'd1, 1'b0, 1'b0);
        #1 chk("t3_rdy_1", a_in_ready, 1);
        tick;
        a_data = 32'h4; a_tag_i = 4'd2;
        #1 chk("t3_rdy_2", a_in_ready, 1);
        tick;
        a_data = 32'h8; a_tag_i = 4'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_full_rdy", a_in_ready, 0);
            chk("t3_hold_vld", a_out_valid, 1);
            chk("t3_hold_tag", a_tag_o, 1);
            chk("t3_hold_res", a_res, 1);
            tick;
        end
        a_out_ready = 1'b1;
        #1;
        chk("t3_rel_rdy", a_in_ready, 1);
        chk("t3_out1_tag", a_tag_o, 1);
        tick;
        a_in_valid = 1'b0;
        #1;
        chk("t3_out2_vld", a_out_valid, 1);
        chk("t3_out2_tag", a_tag_o, 2);
        chk("t3_out2_res", a_res, 2);
        tick;
        #1;
        chk("t3_out3_vld", a_out_valid, 1);
        chk("t3_out3_tag", a_tag_o, 3);
        chk("t3_out3_res", a_res, 3);
        tick;
        #1 chk("t3_empty", a_out_valid, 0);

        // Fill, then flush with a simultaneous input offer.
        a_set(1'b1, 32'h10, 2'd0, 4'd4, 1'b0, 1'b0);
        tick;
        a_tag_i = 4'd5;
        tick;
        a_tag_i = 4'd6; a_flush = 1'b1;
        #1 chk("t4_flush_rdy", a_in_ready, 0);
        tick;
        a_set(1'b0, 32'h0, 2'd0, 4'd0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1 chk("t4_no_stale", a_out_valid, 0);
            tick;
        end

        // Asynchronous reset with two entries in flight.
        a_set(1'b1, 32'h20, 2'd0, 4'd7, 1'b0, 1'b0);
        tick;
        a_tag_i = 4'd8;
        tick;
        a_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", a_out_valid, 0);
        chk("t5_rst_res", a_res, 0);
        chk("t5_rst_nz", a_nz, 0);
        chk("t5_rst_tag", a_tag_o, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick;
        chk("t5_rel_rdy", a_in_ready, 1);
        a_send(32'h0000_0040, 2'd3, 4'd9, 6'd6, 1'b0);

        // Randomized stream with stalls and occasional flushes.
        prev_stall = 1'b0;
        post_flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = ($urandom % 4) != 0;
            rsel        = $urandom % 4;
            a_data      = (rsel == 0) ? 32'h0 : (rsel == 1) ? (32'h1 << ($urandom % 32)) : $urandom;
            a_mode      = 2'($urandom % 4);
            a_tag_i     = 4'($urandom);
            a_out_ready = ($urandom % 4) != 0;
            a_flush     = ($urandom % 25) == 0;
            #1;
            if (post_flush) chk("rnd_post_flush", a_out_valid, 0);
            if (prev_stall) chk("rnd_hold", a_out_valid, 1);
            if (a_flush)    chk("rnd_flush_rdy", a_in_ready, 0);
            if (a_out_valid) begin
                if (q.size() == 0) chk("rnd_spurious", a_out_valid, 0);
                else               chk("rnd_result", {a_nz, a_tag_o, a_res}, q[0]);
            end
            prev_stall = a_out_valid & ~a_out_ready & ~a_flush;
            post_flush = a_flush;
            if (a_flush) begin
                q.delete();
            end else begin
                if (a_out_valid && a_out_ready && q.size() > 0) void'(q.pop_front());
                if (a_in_valid && a_in_ready) begin
                    e = ref_calc(a_data, a_mode, 32);
                    q.push_back({e[6], a_tag_i, e[5:0]});
                end
            end
            tick;
        end
        a_set(1'b0, 32'h0, 2'd0, 4'd0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (a_out_valid) begin
                if (q.size() == 0) chk("drain_spurious", a_out_valid, 0);
                else begin
                    chk("drain_result", {a_nz, a_tag_o, a_res}, q[0]);
                    void'(q.pop_front());
                end
            end
            tick;
        end
        chk("drain_empty", q.size(), 0);

        // LEN=24, three stages.
        b_send(24'h80_0000, 2'd1, 4'd1, 5'd23, 1'b0);
        b_send(24'h80_0000, 2'd2, 4'd2, 5'd0, 1'b0);
        b_send(24'h80_0000, 2'd3, 4'd3, 5'd23, 1'b0);
        b_send(24'h00_0000, 2'd2, 4'd4, 5'd24, 1'b1);
        b_send(24'h00_0000, 2'd3, 4'd5, 5'd24, 1'b1);
        for (int c = 0; c < 20; c++) begin
            logic [23:0] bd;
            logic [1:0]  bm;
            rsel = $urandom % 4;
            bd = (rsel == 0) ? 24'h0 : (rsel == 1) ? (24'h1 << ($urandom % 24)) : 24'($urandom);
            bm = 2'($urandom % 4);
            e  = ref_calc({8'h0, bd}, bm, 24);
            b_send(bd, bm, 4'(c), e[4:0], e[6]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
